// File: rtl/lfsr_stream.sv
// lfsr_stream: Fibonacci LFSR generator driven by a seed/length command and
// streaming each state word out over a valid/ready handshake.
//
// Parameters
//   nbits : LFSR state width (>= 2)
//   taps  : feedback mask, bit i set => lfsr[i] feeds the XOR
//   lw    : width of the length field
//
// Ports
//   clk      : clock, all state updates on posedge
//   rst      : synchronous reset, active low
//   cmd_val  : command valid
//   cmd_rdy  : command ready, high only while idle
//   cmd_seed : initial LFSR state (0 is replaced by 1)
//   cmd_len  : number of words to emit for this command
//   out_val  : output word valid
//   out_rdy  : downstream ready
//   out_data : current LFSR state
//   wrap     : sticky, sequence returned to the effective seed this command
//   zero_fix : sticky, last accepted seed was 0 and was replaced by 1
module lfsr_stream #(
   parameter int unsigned           nbits = 8,
   parameter logic [nbits-1:0]      taps  = 8'hB8,
   parameter int unsigned           lw    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_val,
   output logic             cmd_rdy,
   input  logic [nbits-1:0] cmd_seed,
   input  logic [lw-1:0]    cmd_len,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [nbits-1:0] out_data,
   output logic             wrap,
   output logic             zero_fix
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [nbits-1:0] lfsr_q, lfsr_d;
   logic [nbits-1:0] seed_q, seed_d;
   logic [lw-1:0]    cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             zfix_q, zfix_d;

   logic [nbits-1:0] lfsr_next;
   logic [nbits-1:0] eff_seed;
   logic             cmd_fire;
   logic             out_fire;

   assign lfsr_next = {lfsr_q[nbits-2:0], ^(lfsr_q & taps)};
   assign eff_seed  = (cmd_seed == '0) ? nbits'(1) : cmd_seed;

   // Handshake outputs decode only registered state, so out_val never
   // depends combinationally on out_rdy.
   assign cmd_rdy  = (state_q == IDLE);
   assign out_val  = (state_q == RUN);
   assign out_data = lfsr_q;
   assign wrap     = wrap_q;
   assign zero_fix = zfix_q;

   assign cmd_fire = cmd_val & cmd_rdy;
   assign out_fire = out_val & out_rdy;

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      seed_d  = seed_q;
      cnt_d   = cnt_q;
      wrap_d  = wrap_q;
      zfix_d  = zfix_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               lfsr_d = eff_seed;
               seed_d = eff_seed;
               cnt_d  = cmd_len;
               wrap_d = 1'b0;
               zfix_d = (cmd_seed == '0);
               if (cmd_len != '0) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (out_fire) begin
               lfsr_d = lfsr_next;
               // cnt_q is at least 1 in RUN, so this never underflows.
               cnt_d  = cnt_q - lw'(1);
               if (lfsr_next == seed_q) begin
                  wrap_d = 1'b1;
               end
               if (cnt_q == lw'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         lfsr_q  <= '0;
         seed_q  <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         zfix_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         seed_q  <= seed_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         zfix_q  <= zfix_d;
      end
   end

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed testbench for lfsr_stream (nbits=8, taps=8'hB8, lw=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lfsr_stream;

   logic        clk;
   logic        rst;
   logic        cmd_val;
   logic        cmd_rdy;
   logic [7:0]  cmd_seed;
   logic [15:0] cmd_len;
   logic        out_val;
   logic        out_rdy;
   logic [7:0]  out_data;
   logic        wrap;
   logic        zero_fix;

   int unsigned n_cmp;
   int unsigned n_err;

   lfsr_stream #(
      .nbits (8),
      .taps  (8'hB8),
      .lw    (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_val  (cmd_val),
      .cmd_rdy  (cmd_rdy),
      .cmd_seed (cmd_seed),
      .cmd_len  (cmd_len),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .wrap     (wrap),
      .zero_fix (zero_fix)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Present a command for one posedge; returns on the negedge after acceptance.
   task automatic send_cmd(input logic [7:0] seed, input logic [15:0] len);
      cmd_val  = 1'b1;
      cmd_seed = seed;
      cmd_len  = len;
      @(negedge clk);
      cmd_val  = 1'b0;
   endtask

   logic [7:0] model;
   logic [7:0] bp_exp [6];
   logic       bp_rdy [6];
   int unsigned xfers;

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b0;
      cmd_val  = 1'b0;
      cmd_seed = '0;
      cmd_len  = '0;
      out_rdy  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_cmd_rdy",  32'(cmd_rdy),  32'd1);
      check_val("rst_out_val",  32'(out_val),  32'd0);
      check_val("rst_out_data", 32'(out_data), 32'h00);
      check_val("rst_wrap",     32'(wrap),     32'd0);
      check_val("rst_zero_fix", 32'(zero_fix), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // seed 01, len 4, no backpressure
      out_rdy = 1'b1;
      send_cmd(8'h01, 16'd4);
      check_val("t1_w0_val", 32'(out_val),  32'd1);
      check_val("t1_w0",     32'(out_data), 32'h01);
      @(negedge clk);
      check_val("t1_w1",     32'(out_data), 32'h02);
      @(negedge clk);
      check_val("t1_w2",     32'(out_data), 32'h04);
      @(negedge clk);
      check_val("t1_w3",     32'(out_data), 32'h08);
      check_val("t1_w3_rdy", 32'(cmd_rdy),  32'd0);
      @(negedge clk);
      check_val("t1_end_val",  32'(out_val),  32'd0);
      check_val("t1_end_rdy",  32'(cmd_rdy),  32'd1);
      check_val("t1_end_wrap", 32'(wrap),     32'd0);
      check_val("t1_end_zf",   32'(zero_fix), 32'd0);
      check_val("t1_end_data", 32'(out_data), 32'h11);

      // Zero seed replaced by 1, back-to-back with previous command
      send_cmd(8'h00, 16'd2);
      check_val("t2_zf", 32'(zero_fix), 32'd1);
      check_val("t2_w0", 32'(out_data), 32'h01);
      @(negedge clk);
      check_val("t2_w1", 32'(out_data), 32'h02);
      @(negedge clk);
      check_val("t2_end_val", 32'(out_val), 32'd0);

      // Long run across a full period: 300 words, wrap after word 255
      send_cmd(8'h01, 16'd300);
      check_val("t3_zf", 32'(zero_fix), 32'd0);
      model = 8'h01;
      xfers = 0;
      for (int unsigned i = 0; i < 300; i++) begin
         check_val("t3_val",  32'(out_val),  32'd1);
         check_val("t3_word", 32'(out_data), 32'(model));
         if (i == 4)   check_val("t3_after08", 32'(out_data), 32'h11);
         if (i == 254) check_val("t3_wrap_pre", 32'(wrap), 32'd0);
         if (i == 255) begin
            check_val("t3_wrap_post", 32'(wrap),     32'd1);
            check_val("t3_word256",   32'(out_data), 32'h01);
         end
         if (out_val) xfers++;
         model = {model[6:0], model[7] ^ model[5] ^ model[4] ^ model[3]};
         @(negedge clk);
      end
      check_val("t3_xfers",    32'(xfers),   32'd300);
      check_val("t3_end_val",  32'(out_val), 32'd0);
      check_val("t3_end_rdy",  32'(cmd_rdy), 32'd1);
      check_val("t3_end_wrap", 32'(wrap),    32'd1);

      // Backpressure: out_rdy 1,0,0,1,0,1
      bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      bp_exp = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04};
      out_rdy = 1'b0;
      send_cmd(8'h01, 16'd3);
      check_val("t4_wrap_clr", 32'(wrap), 32'd0);
      for (int unsigned i = 0; i < 6; i++) begin
         check_val("t4_val",  32'(out_val),  32'd1);
         check_val("t4_data", 32'(out_data), 32'(bp_exp[i]));
         check_val("t4_crdy", 32'(cmd_rdy),  32'd0);
         out_rdy = bp_rdy[i];
         @(negedge clk);
      end
      check_val("t4_end_val", 32'(out_val), 32'd0);
      check_val("t4_end_rdy", 32'(cmd_rdy), 32'd1);

      // len 0: flags/state update but no words
      out_rdy = 1'b1;
      send_cmd(8'h5A, 16'd0);
      check_val("t5_val",  32'(out_val),  32'd0);
      check_val("t5_rdy",  32'(cmd_rdy),  32'd1);
      check_val("t5_data", 32'(out_data), 32'h5A);
      @(negedge clk);
      check_val("t5_val2", 32'(out_val),  32'd0);

      // cmd_val during RUN is ignored
      out_rdy = 1'b0;
      send_cmd(8'h01, 16'd5);
      check_val("t6_w0", 32'(out_data), 32'h01);
      cmd_val  = 1'b1;
      cmd_seed = 8'h00;
      cmd_len  = 16'd1;
      @(negedge clk);
      cmd_val  = 1'b0;
      check_val("t6_hold", 32'(out_data), 32'h01);
      check_val("t6_crdy", 32'(cmd_rdy),  32'd0);
      check_val("t6_zf",   32'(zero_fix), 32'd0);
      out_rdy = 1'b1;
      @(negedge clk);
      check_val("t6_w1", 32'(out_data), 32'h02);
      @(negedge clk);
      check_val("t6_w2", 32'(out_data), 32'h04);
      @(negedge clk);
      check_val("t6_w3", 32'(out_data), 32'h08);
      @(negedge clk);
      check_val("t6_w4",     32'(out_data), 32'h11);
      check_val("t6_w4_val", 32'(out_val),  32'd1);
      @(negedge clk);
      check_val("t6_end_val", 32'(out_val), 32'd0);

      // Reset mid-run after 2 of 10 words
      send_cmd(8'h00, 16'd10);
      check_val("t7_w0", 32'(out_data), 32'h01);
      check_val("t7_zf", 32'(zero_fix), 32'd1);
      @(negedge clk);
      check_val("t7_w1", 32'(out_data), 32'h02);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check_val("t7_val",  32'(out_val),  32'd0);
      check_val("t7_rdy",  32'(cmd_rdy),  32'd1);
      check_val("t7_data", 32'(out_data), 32'h00);
      check_val("t7_wrap", 32'(wrap),     32'd0);
      check_val("t7_zf0",  32'(zero_fix), 32'd0);
      @(negedge clk);
      check_val("t7_val2", 32'(out_val),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
